// File: rtl/tdef_pkg.sv
// Shared types and decode helpers for the encoder/hall position front end.
package tdef_pkg;

    // Result of comparing two consecutive filtered quadrature samples.
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Angle width seen by current_loop.
    localparam int unsigned EPOS_W = 16;

    // Angle sample plus its update strobe, as consumed by current_loop.
    typedef struct packed {
        logic [EPOS_W-1:0] epos;
        logic              val;
    } enc_pos_t;

    // Hall sector (0..5) and whether the raw code was legal.
    typedef struct packed {
        logic [2:0] sector;
        logic       valid;
    } hall_sect_t;

    // Map a hall code to its sector; 0 and 7 are illegal.
    function automatic hall_sect_t hall_lookup(input logic [2:0] code);
        hall_sect_t r;
        r.sector = 3'd0;
        r.valid  = 1'b1;
        case (code)
            3'd1:    r.sector = 3'd0;
            3'd3:    r.sector = 3'd1;
            3'd2:    r.sector = 3'd2;
            3'd6:    r.sector = 3'd3;
            3'd4:    r.sector = 3'd4;
            3'd5:    r.sector = 3'd5;
            default: r.valid  = 1'b0;
        endcase
        return r;
    endfunction

    // Next sector in the forward direction, modulo 6.
    function automatic logic [2:0] sect_next(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    // Position of a {B,A} pair along the forward Gray sequence 00,01,11,10.
    function automatic logic [1:0] quad_idx(input logic [1:0] ab);
        logic [1:0] r;
        case (ab)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            2'b11:   r = 2'd2;
            2'b10:   r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Classify a quadrature transition; a distance of 2 means both bits moved.
    function automatic step_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        step_e      r;
        d = quad_idx(cur) - quad_idx(prev);
        case (d)
            2'd0:    r = STEP_NONE;
            2'd1:    r = STEP_FWD;
            2'd3:    r = STEP_REV;
            default: r = STEP_ERR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/in_filter.sv
// Two-flop synchroniser followed by a run-length stability filter.
// The output adopts a new value once FLT_LEN consecutive synchronised
// samples agree, giving an input-to-output latency of 2+FLT_LEN cycles.
module in_filter #(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned FLT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam logic [3:0] RUN_MAX = 4'(FLT_LEN);

    logic [WIDTH-1:0] sync1_q, sync2_q, last_q, flt_q, flt_d;
    logic [3:0]       run_q, run_d;

    // Count consecutive identical samples and accept the value once the run is long enough.
    always_comb begin
        run_d = run_q;
        flt_d = flt_q;
        if (sync2_q != last_q) begin
            run_d = 4'd1;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 4'd1;
        end else begin
            run_d = run_q;
        end
        if ((run_d == RUN_MAX) && (sync2_q != flt_q)) begin
            flt_d = sync2_q;
        end else begin
            flt_d = flt_q;
        end
    end

    // Synchroniser, previous-sample and filter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {WIDTH{1'b0}};
            sync2_q <= {WIDTH{1'b0}};
            last_q  <= {WIDTH{1'b0}};
            flt_q   <= {WIDTH{1'b0}};
            run_q   <= 4'd0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            flt_q   <= flt_d;
            run_q   <= run_d;
        end
    end

    assign dout_o = flt_q;

endmodule

// File: rtl/enc_hall_pos.sv
// Encoder/hall position and speed front end: filters the raw pins, decodes
// quadrature steps into a wrapping position counter realigned by hall edges,
// scales it to a full-scale electrical angle and accumulates per-window speed.
module enc_hall_pos
    import tdef_pkg::*;
#(
    parameter int unsigned SYSRG_W  = 16,
    parameter int unsigned CPR_E    = 1000,
    parameter int unsigned FLT_LEN  = 4,
    parameter int unsigned HALL_OFS = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                enc_in,
    input  logic [2:0]                hall_in,
    input  logic                      align_en,
    input  logic                      spd_stb,
    input  logic                      err_clr,
    output logic [SYSRG_W-1:0]        epos,
    output logic                      epos_val,
    output logic signed [SYSRG_W-1:0] speed,
    output logic                      speed_val,
    output logic                      dir,
    output logic                      enc_err,
    output logic                      hall_err
);

    localparam int unsigned CW = SYSRG_W;
    localparam int unsigned PW = 2 * SYSRG_W + 17;
    localparam logic [CW-1:0] CNT_MAX = CW'(CPR_E - 1);
    localparam logic [SYSRG_W+16:0] K_SCALE = (SYSRG_W+17)'((64'd1 << (SYSRG_W + 16)) / 64'(CPR_E));
    localparam logic signed [SYSRG_W:0] ACC_ONE  = (SYSRG_W+1)'(1);
    localparam logic signed [SYSRG_W:0] ACC_NEG1 = {(SYSRG_W+1){1'b1}};
    localparam logic signed [SYSRG_W:0] ACC_ZERO = {(SYSRG_W+1){1'b0}};
    localparam logic signed [SYSRG_W:0] ACC_MAX  = {1'b0, {SYSRG_W{1'b1}}};
    localparam logic signed [SYSRG_W:0] ACC_MIN  = {1'b1, {SYSRG_W{1'b0}}};
    localparam logic signed [SYSRG_W:0] SPD_MAX  = {2'b00, {(SYSRG_W-1){1'b1}}};
    localparam logic signed [SYSRG_W:0] SPD_MIN  = {2'b11, {(SYSRG_W-2){1'b0}}, 1'b1};

    // Count loaded when the rotor crosses from sector s to s+1 (or back).
    function automatic logic [CW-1:0] boundary(input logic [2:0] s);
        longint unsigned b;
        b = (64'(HALL_OFS) + (64'(s) + 64'd1) * 64'(CPR_E) / 64'd6) % 64'(CPR_E);
        return CW'(b);
    endfunction

    logic [1:0]  enc_f_s;
    logic [2:0]  hall_f_s;
    logic [1:0]  enc_prev_q;
    logic [2:0]  hall_prev_q;
    step_e       step_s;
    hall_sect_t  hcur_s, hprv_s;
    logic        hall_adj_s, hall_err_set_s, hall_reload_s;
    logic [CW-1:0] hall_bnd_s;

    logic [CW-1:0]             cnt_q, cnt_d, cnt_step_s;
    logic                      chg_q;
    logic [SYSRG_W-1:0]        epos_q, epos_d;
    logic                      epos_val_q;
    logic signed [SYSRG_W:0]   acc_q, acc_d;
    logic signed [SYSRG_W-1:0] speed_q, speed_d;
    logic                      speed_val_q;
    logic                      dir_q, dir_d;
    logic                      enc_err_q, enc_err_d;
    logic                      hall_err_q, hall_err_d;

    in_filter #(.WIDTH(2), .FLT_LEN(FLT_LEN)) u_enc_flt (
        .clk    (clk),
        .rst    (rst),
        .din_i  (enc_in),
        .dout_o (enc_f_s)
    );

    in_filter #(.WIDTH(3), .FLT_LEN(FLT_LEN)) u_hall_flt (
        .clk    (clk),
        .rst    (rst),
        .din_i  (hall_in),
        .dout_o (hall_f_s)
    );

    assign step_s = quad_decode(enc_prev_q, enc_f_s);

    // Classify a hall code change as adjacent (reload candidate), illegal, or ignorable.
    always_comb begin
        hcur_s         = hall_lookup(hall_f_s);
        hprv_s         = hall_lookup(hall_prev_q);
        hall_adj_s     = 1'b0;
        hall_err_set_s = 1'b0;
        hall_bnd_s     = {CW{1'b0}};
        if (hall_f_s != hall_prev_q) begin
            if (!hcur_s.valid) begin
                hall_err_set_s = 1'b1;
            end else if (!hprv_s.valid) begin
                // Leaving an illegal code gives no reference sector: nothing to realign.
                hall_adj_s = 1'b0;
            end else if (sect_next(hprv_s.sector) == hcur_s.sector) begin
                hall_adj_s = 1'b1;
                hall_bnd_s = boundary(hprv_s.sector);
            end else if (sect_next(hcur_s.sector) == hprv_s.sector) begin
                hall_adj_s = 1'b1;
                hall_bnd_s = boundary(hcur_s.sector);
            end else begin
                hall_err_set_s = 1'b1;
            end
        end else begin
            hall_adj_s = 1'b0;
        end
    end

    assign hall_reload_s = hall_adj_s & align_en;

    // Wrapping position step, then let a hall reload take precedence.
    always_comb begin
        cnt_step_s = cnt_q;
        case (step_s)
            STEP_FWD: cnt_step_s = (cnt_q == CNT_MAX) ? {CW{1'b0}} : cnt_q + CW'(1);
            STEP_REV: cnt_step_s = (cnt_q == {CW{1'b0}}) ? CNT_MAX : cnt_q - CW'(1);
            default:  cnt_step_s = cnt_q;
        endcase
        cnt_d = hall_reload_s ? hall_bnd_s : cnt_step_s;
    end

    // Scale the settled count to a full-scale angle one cycle after it moved.
    always_comb begin
        epos_d = epos_q;
        if (chg_q) begin
            epos_d = SYSRG_W'((PW'(cnt_q) * PW'(K_SCALE)) >> 16);
        end else begin
            epos_d = epos_q;
        end
    end

    // Saturating step accumulator; a window close publishes it and restarts from this cycle's step.
    always_comb begin
        acc_d   = acc_q;
        speed_d = speed_q;
        if (spd_stb) begin
            if (acc_q > SPD_MAX) begin
                speed_d = SPD_MAX[SYSRG_W-1:0];
            end else if (acc_q < SPD_MIN) begin
                speed_d = SPD_MIN[SYSRG_W-1:0];
            end else begin
                speed_d = acc_q[SYSRG_W-1:0];
            end
            case (step_s)
                STEP_FWD: acc_d = ACC_ONE;
                STEP_REV: acc_d = ACC_NEG1;
                default:  acc_d = ACC_ZERO;
            endcase
        end else begin
            case (step_s)
                STEP_FWD: acc_d = (acc_q == ACC_MAX) ? acc_q : acc_q + ACC_ONE;
                STEP_REV: acc_d = (acc_q == ACC_MIN) ? acc_q : acc_q - ACC_ONE;
                default:  acc_d = acc_q;
            endcase
        end
    end

    // Direction follows valid steps only; error flags are sticky and a new event beats err_clr.
    always_comb begin
        case (step_s)
            STEP_FWD: dir_d = 1'b1;
            STEP_REV: dir_d = 1'b0;
            default:  dir_d = dir_q;
        endcase
        if (step_s == STEP_ERR) begin
            enc_err_d = 1'b1;
        end else if (err_clr) begin
            enc_err_d = 1'b0;
        end else begin
            enc_err_d = enc_err_q;
        end
        if (hall_err_set_s) begin
            hall_err_d = 1'b1;
        end else if (err_clr) begin
            hall_err_d = 1'b0;
        end else begin
            hall_err_d = hall_err_q;
        end
    end

    // All datapath and output state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_prev_q  <= 2'b00;
            hall_prev_q <= 3'b000;
            cnt_q       <= {CW{1'b0}};
            chg_q       <= 1'b0;
            epos_q      <= {SYSRG_W{1'b0}};
            epos_val_q  <= 1'b0;
            acc_q       <= ACC_ZERO;
            speed_q     <= {SYSRG_W{1'b0}};
            speed_val_q <= 1'b0;
            dir_q       <= 1'b0;
            enc_err_q   <= 1'b0;
            hall_err_q  <= 1'b0;
        end else begin
            enc_prev_q  <= enc_f_s;
            hall_prev_q <= hall_f_s;
            cnt_q       <= cnt_d;
            chg_q       <= (cnt_d != cnt_q);
            epos_q      <= epos_d;
            epos_val_q  <= chg_q;
            acc_q       <= acc_d;
            speed_q     <= speed_d;
            speed_val_q <= spd_stb;
            dir_q       <= dir_d;
            enc_err_q   <= enc_err_d;
            hall_err_q  <= hall_err_d;
        end
    end

    assign epos      = epos_q;
    assign epos_val  = epos_val_q;
    assign speed     = speed_q;
    assign speed_val = speed_val_q;
    assign dir       = dir_q;
    assign enc_err   = enc_err_q;
    assign hall_err  = hall_err_q;

endmodule

// File: tb/tb_enc_hall_pos.sv
// Scoreboard bench for enc_hall_pos with default parameters (W=16, CPR_E=1000, FLT_LEN=4).
module tb_enc_hall_pos;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  enc_in;
    logic [2:0]  hall_in;
    logic        align_en, spd_stb, err_clr;
    logic [15:0] epos;
    logic        epos_val;
    logic signed [15:0] speed;
    logic        speed_val, dir, enc_err, hall_err;

    int checks = 0;
    int failures = 0;
    int exp_epos_q[$];
    int exp_speed_q[$];
    int epos_pulses = 0;
    int m_cnt = 0;
    int m_acc = 0;
    int enc_idx = 0;

    always #5 clk = ~clk;

    enc_hall_pos #(.SYSRG_W(16), .CPR_E(1000), .FLT_LEN(4), .HALL_OFS(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .enc_in    (enc_in),
        .hall_in   (hall_in),
        .align_en  (align_en),
        .spd_stb   (spd_stb),
        .err_clr   (err_clr),
        .epos      (epos),
        .epos_val  (epos_val),
        .speed     (speed),
        .speed_val (speed_val),
        .dir       (dir),
        .enc_err   (enc_err),
        .hall_err  (hall_err)
    );

    function automatic int exp_epos(input int c);
        longint unsigned k;
        k = (64'd1 << 32) / 64'd1000;
        return int'((longint'(c) * k) >> 16);
    endfunction

    function automatic logic [1:0] gray_of(input int i);
        logic [1:0] r;
        case (i)
            0: r = 2'b00;
            1: r = 2'b01;
            2: r = 2'b11;
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    // Advance n cycles, popping and comparing the scoreboard on every output pulse.
    task automatic tick(input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (epos_val === 1'b1) begin
                epos_pulses++;
                checks++;
                if (exp_epos_q.size() == 0) begin
                    failures++;
                    $display("FAIL epos_unexpected got=%0d expected=no_pulse", epos);
                end else begin
                    e = exp_epos_q.pop_front();
                    if (epos !== 16'(e)) begin
                        failures++;
                        $display("FAIL epos_sb got=%0d expected=%0d", epos, e);
                    end
                end
            end
            if (speed_val === 1'b1) begin
                checks++;
                if (exp_speed_q.size() == 0) begin
                    failures++;
                    $display("FAIL speed_unexpected got=%0d expected=no_pulse", speed);
                end else begin
                    e = exp_speed_q.pop_front();
                    if (speed !== 16'(e)) begin
                        failures++;
                        $display("FAIL speed_sb got=%0d expected=%0d", speed, e);
                    end
                end
            end
        end
    endtask

    // Drive one quadrature step and update the model.
    task automatic model_step(input bit fwd);
        if (fwd) begin
            m_cnt = (m_cnt == 999) ? 0 : m_cnt + 1;
            m_acc = m_acc + 1;
            enc_idx = (enc_idx + 1) % 4;
        end else begin
            m_cnt = (m_cnt == 0) ? 999 : m_cnt - 1;
            m_acc = m_acc - 1;
            enc_idx = (enc_idx + 3) % 4;
        end
        exp_epos_q.push_back(exp_epos(m_cnt));
        enc_in = gray_of(enc_idx);
    endtask

    task automatic do_step(input bit fwd);
        model_step(fwd);
        tick(9);
    endtask

    task automatic close_window();
        spd_stb = 1'b1;
        exp_speed_q.push_back(m_acc);
        m_acc = 0;
        tick(1);
        spd_stb = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        align_en = 1'b0; spd_stb = 1'b0; err_clr = 1'b0;
        enc_in = 2'b00; hall_in = 3'b000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            enc_in = 2'($urandom_range(0, 3));
            hall_in = 3'($urandom_range(0, 7));
            spd_stb = ~spd_stb;
        end
        @(negedge clk);
        checks++;
        if ({epos, epos_val, speed, speed_val, dir, enc_err, hall_err} !== 37'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {epos, epos_val, speed, speed_val, dir, enc_err, hall_err});
        end
        enc_in = 2'b00; hall_in = 3'b000; spd_stb = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(12);
        checks++;
        if (epos !== 16'd0 || speed !== 16'sd0) begin
            failures++;
            $display("FAIL post_reset got epos=%0d speed=%0d expected=0", epos, speed);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = epos_pulses;
        enc_in = 2'b01;
        tick(2);
        enc_in = 2'b00;
        tick(12);
        checks++;
        if (epos_pulses != p0 || epos !== 16'd0) begin
            failures++;
            $display("FAIL glitch got pulses=%0d epos=%0d expected 0/0", epos_pulses - p0, epos);
        end
        checks++;
        if (dir !== 1'b0 || enc_err !== 1'b0) begin
            failures++;
            $display("FAIL glitch_flags got dir=%b enc_err=%b expected 0/0", dir, enc_err);
        end
    endtask

    task automatic test_forward();
        int p0;
        p0 = epos_pulses;
        repeat (250) do_step(1'b1);
        checks++;
        if (epos !== 16'd16383 || dir !== 1'b1) begin
            failures++;
            $display("FAIL fwd250 got epos=%0d dir=%b expected 16383/1", epos, dir);
        end
        checks++;
        if (epos_pulses - p0 != 250) begin
            failures++;
            $display("FAIL fwd_pulses got=%0d expected=250", epos_pulses - p0);
        end
    endtask

    task automatic test_reverse_wrap();
        repeat (250) do_step(1'b0);
        checks++;
        if (epos !== 16'd0) begin
            failures++;
            $display("FAIL rev_to_zero got=%0d expected=0", epos);
        end
        do_step(1'b0);
        checks++;
        if (epos !== 16'd65470 || dir !== 1'b0) begin
            failures++;
            $display("FAIL rev_wrap got epos=%0d dir=%b expected 65470/0", epos, dir);
        end
        do_step(1'b1);
        checks++;
        if (epos !== 16'd0 || dir !== 1'b1) begin
            failures++;
            $display("FAIL fwd_wrap got epos=%0d dir=%b expected 0/1", epos, dir);
        end
    endtask

    task automatic test_illegal();
        int p0;
        p0 = epos_pulses;
        enc_idx = (enc_idx + 2) % 4;
        enc_in = gray_of(enc_idx);
        tick(9);
        checks++;
        if (enc_err !== 1'b1 || epos_pulses != p0 || epos !== 16'd0 || dir !== 1'b1) begin
            failures++;
            $display("FAIL illegal got enc_err=%b pulses=%0d epos=%0d dir=%b expected 1/0/0/1",
                     enc_err, epos_pulses - p0, epos, dir);
        end
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        checks++;
        if (enc_err !== 1'b0) begin
            failures++;
            $display("FAIL enc_err_clr got=%b expected=0", enc_err);
        end
        // err_clr landing in the same cycle as a new illegal step must not win.
        enc_idx = (enc_idx + 2) % 4;
        enc_in = gray_of(enc_idx);
        tick(6);
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(2);
        checks++;
        if (enc_err !== 1'b1) begin
            failures++;
            $display("FAIL enc_err_vs_clr got=%b expected=1", enc_err);
        end
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    endtask

    task automatic test_hall();
        align_en = 1'b1;
        hall_in = 3'd1;
        tick(9);
        checks++;
        if (hall_err !== 1'b0 || epos !== 16'd0) begin
            failures++;
            $display("FAIL hall_first got hall_err=%b epos=%0d expected 0/0", hall_err, epos);
        end
        hall_in = 3'd3;
        m_cnt = 166;
        exp_epos_q.push_back(exp_epos(m_cnt));
        tick(9);
        checks++;
        if (epos !== 16'd10878 || hall_err !== 1'b0) begin
            failures++;
            $display("FAIL hall_reload got epos=%0d hall_err=%b expected 10878/0", epos, hall_err);
        end
        hall_in = 3'd4;
        tick(9);
        checks++;
        if (hall_err !== 1'b1 || epos !== 16'd10878) begin
            failures++;
            $display("FAIL hall_jump got hall_err=%b epos=%0d expected 1/10878", hall_err, epos);
        end
        hall_in = 3'd7;
        tick(9);
        checks++;
        if (hall_err !== 1'b1) begin
            failures++;
            $display("FAIL hall_code7 got=%b expected=1", hall_err);
        end
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        checks++;
        if (hall_err !== 1'b0) begin
            failures++;
            $display("FAIL hall_err_clr got=%b expected=0", hall_err);
        end
    endtask

    task automatic test_speed();
        int sv;
        close_window();
        repeat (37) do_step(1'b1);
        spd_stb = 1'b1;
        exp_speed_q.push_back(m_acc);
        m_acc = 0;
        tick(1);
        spd_stb = 1'b0;
        checks++;
        if (speed_val !== 1'b1 || speed !== 16'sd37) begin
            failures++;
            $display("FAIL speed37 got val=%b speed=%0d expected 1/37", speed_val, speed);
        end
        tick(1);
        checks++;
        if (speed_val !== 1'b0) begin
            failures++;
            $display("FAIL speed_val_width got=%b expected=0", speed_val);
        end
        repeat (5) do_step(1'b0);
        sv = m_acc;
        model_step(1'b0);
        tick(6);
        spd_stb = 1'b1;
        exp_speed_q.push_back(sv);
        m_acc = -1;
        tick(1);
        spd_stb = 1'b0;
        checks++;
        if (speed !== -16'sd5) begin
            failures++;
            $display("FAIL speed_m5 got=%0d expected=-5", speed);
        end
        tick(8);
        close_window();
        checks++;
        if (speed !== -16'sd1 || dir !== 1'b0) begin
            failures++;
            $display("FAIL speed_carry got speed=%0d dir=%b expected -1/0", speed, dir);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_forward();
        test_reverse_wrap();
        test_illegal();
        test_hall();
        test_speed();
        tick(4);
        checks++;
        if (exp_epos_q.size() != 0 || exp_speed_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got epos_left=%0d speed_left=%0d expected 0/0",
                     exp_epos_q.size(), exp_speed_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
